// File: rtl/mem_stall_pkg.sv
// Shared types and helpers for the memory-access stall controller.
// The watchdog build option is MEM_STALL_TIMEOUT_EN (see mem_port_fsm).
package mem_stall_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} port_state_t;

    localparam int TIMEOUT_CYC_DEF = 255;

    // Width needed to hold counts 0..maxCount, never narrower than one bit.
    function automatic int cnt_width(input int maxCount);
        return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// One memory port: request/done handshake FSM, read-data latch and, when
// MEM_STALL_TIMEOUT_EN is defined, a WAIT watchdog that forces completion.
module mem_port_fsm
    import mem_stall_pkg::*;
#(
    parameter int DW = 32
`ifdef MEM_STALL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          done_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          release_i,
    output port_state_t   state_o,
    output logic          req_o,
    output logic [DW-1:0] rdata_hold_o,
    output logic          err_o,
    output logic          spurious_o
);

    port_state_t   state_q, state_d;
    logic [DW-1:0] rdata_q, rdata_d;

`ifdef MEM_STALL_TIMEOUT_EN
    localparam int CW = cnt_width(TIMEOUT_CYC);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef MEM_STALL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) state_d = REQ;
            end
            REQ: begin
                if (done_i) begin
                    state_d = DONE;
                    rdata_d = rdata_i;
                end else begin
                    state_d = WAIT;
`ifdef MEM_STALL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (done_i) begin
                    state_d = DONE;
                    rdata_d = rdata_i;
                end
`ifdef MEM_STALL_TIMEOUT_EN
                // Count reaching TIMEOUT_CYC-1 here means this is the last allowed WAIT cycle.
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = DONE;
                    rdata_d = '1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            DONE: begin
                if (release_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
`ifdef MEM_STALL_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
`ifdef MEM_STALL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign state_o      = state_q;
    assign req_o        = (state_q == REQ);
    assign rdata_hold_o = rdata_q;
    assign spurious_o   = done_i && ((state_q == IDLE) || (state_q == DONE));

`ifdef MEM_STALL_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stall_ctrl.sv
// Multi-port memory stall controller: freezes PC and pipeline enables until every
// outstanding access completes. Optional watchdog: MEM_STALL_TIMEOUT_EN.
module mem_stall_ctrl
    import mem_stall_pkg::*;
#(
    parameter int N_PORTS  = 2,
    parameter int N_STAGES = 4,
    parameter int DW       = 32
`ifdef MEM_STALL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_PORTS-1:0]    start,
    input  logic [N_PORTS-1:0]    done,
    input  logic [N_PORTS*DW-1:0] rdata,
    input  logic [N_STAGES-1:0]   enable_in,
    input  logic                  enable_pc_in,
    output logic [N_STAGES-1:0]   enable_out,
    output logic                  enable_pc_out,
    output logic [N_PORTS-1:0]    req_out,
    output logic [N_PORTS*DW-1:0] rdata_hold,
    output logic                  busy,
    output logic                  spurious,
    output logic [N_PORTS-1:0]    err
);

    port_state_t        portState [N_PORTS];
    logic [N_PORTS-1:0] idleVec, activeVec, doneVec, spurPulse;
    logic               stall, releaseAll;
    logic               spurious_q, spurious_d;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        mem_port_fsm #(
            .DW          (DW)
`ifdef MEM_STALL_TIMEOUT_EN
            , .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
        ) u_fsm (
            .clk_i        (CLK),
            .rst_i        (RST),
            .start_i      (start[p]),
            .done_i       (done[p]),
            .rdata_i      (rdata[p*DW +: DW]),
            .release_i    (releaseAll),
            .state_o      (portState[p]),
            .req_o        (req_out[p]),
            .rdata_hold_o (rdata_hold[p*DW +: DW]),
            .err_o        (err[p]),
            .spurious_o   (spurPulse[p])
        );

        assign idleVec[p]   = (portState[p] == IDLE);
        assign activeVec[p] = (portState[p] == REQ) || (portState[p] == WAIT);
        assign doneVec[p]   = (portState[p] == DONE);
    end

    // A fresh start stalls in its own cycle so the instruction waits for REQ.
    assign stall      = (|(start & idleVec)) || (|activeVec);
    assign releaseAll = !stall && (|doneVec);
    assign busy       = |activeVec;

    assign enable_out    = enable_in & {N_STAGES{~stall}};
    assign enable_pc_out = enable_pc_in & ~stall;

    assign spurious_d = spurious_q || (|spurPulse);

    always_ff @(posedge CLK) begin
        if (RST) spurious_q <= 1'b0;
        else     spurious_q <= spurious_d;
    end

    assign spurious = spurious_q;

endmodule
